// File: rtl/ecc_err_logger_if.sv
// Decoder-status input and error-record drain port for ecc_err_logger.
// The master drives decoder status and rec_ready_i; the slave (the logger) drives the record head.
interface ecc_err_logger_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned SYN_W  = 5
);
  logic              valid_i;
  logic [ADDR_W-1:0] addr_i;
  logic [SYN_W-1:0]  syndrome_i;
  logic              sb_err_i;
  logic              db_err_i;
  logic              sb_fix_i;

  logic              rec_valid_o;
  logic              rec_ready_i;
  logic [ADDR_W-1:0] rec_addr_o;
  logic [SYN_W-1:0]  rec_syn_o;
  logic              rec_db_o;
  logic              rec_fix_o;

  modport master (
    output valid_i, addr_i, syndrome_i, sb_err_i, db_err_i, sb_fix_i, rec_ready_i,
    input  rec_valid_o, rec_addr_o, rec_syn_o, rec_db_o, rec_fix_o
  );

  modport slave (
    input  valid_i, addr_i, syndrome_i, sb_err_i, db_err_i, sb_fix_i, rec_ready_i,
    output rec_valid_o, rec_addr_o, rec_syn_o, rec_db_o, rec_fix_o
  );
endinterface

// File: rtl/ecc_err_logger.sv
// SEC-DED error logger: saturating sb/db counters, record FIFO, irq FSM.
// Optional first-event capture enabled by defining ECC_LOG_FIRST_ERR_EN.
module ecc_err_logger #(
  parameter int unsigned SYN_W     = 5,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOG_DEPTH = 4,
  parameter int unsigned SB_THRESH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ecc_err_logger_if.slave   bus,
  input  logic              clr_i,
  input  logic              irq_ack_i,
  output logic [CNT_W-1:0]  sb_cnt_o,
  output logic [CNT_W-1:0]  db_cnt_o,
  output logic              ovf_o,
  output logic              irq_o,
  output logic [ADDR_W-1:0] first_addr_o,
  output logic [SYN_W-1:0]  first_syn_o
);

  localparam int unsigned AW = $clog2(LOG_DEPTH);
  localparam int unsigned RW = ADDR_W + SYN_W + 2;
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(SB_THRESH - 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t state_q, state_d;

  logic evt, sb_inc, db_inc, thresh_hit, trig;

  // Events coincident with clr_i are discarded entirely.
  assign evt        = bus.valid_i & (bus.sb_err_i | bus.db_err_i) & ~clr_i;
  assign db_inc     = evt & bus.db_err_i;
  assign sb_inc     = evt & ~bus.db_err_i;
  assign thresh_hit = sb_inc & (sb_cnt_o == THRESH_M1);
  assign trig       = db_inc | thresh_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_cnt_o <= '0;
      db_cnt_o <= '0;
    end else if (clr_i) begin
      sb_cnt_o <= '0;
      db_cnt_o <= '0;
    end else begin
      if (sb_inc && (sb_cnt_o != '1)) sb_cnt_o <= sb_cnt_o + 1'b1;
      if (db_inc && (db_cnt_o != '1)) db_cnt_o <= db_cnt_o + 1'b1;
    end
  end

  logic [RW-1:0] mem [LOG_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push, drop;
  logic [RW-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & bus.rec_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push  = evt & (~full | pop);
  assign drop  = evt & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_o  <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) ovf_o  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.addr_i, bus.syndrome_i, bus.db_err_i, bus.sb_fix_i};
  end

  // Record fields read as zero whenever no record is present.
  assign head            = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.rec_valid_o = ~empty;
  assign bus.rec_addr_o  = head[RW-1 -: ADDR_W];
  assign bus.rec_syn_o   = head[SYN_W+1 : 2];
  assign bus.rec_db_o    = head[1];
  assign bus.rec_fix_o   = head[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    irq_o   = 1'b0;
    unique case (state_q)
      IDLE: if (trig) state_d = PEND;
      PEND: begin
        irq_o = 1'b1;
        if (irq_ack_i && !trig) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

`ifdef ECC_LOG_FIRST_ERR_EN
  logic captured_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      captured_q   <= 1'b0;
      first_addr_o <= '0;
      first_syn_o  <= '0;
    end else if (clr_i) begin
      captured_q   <= 1'b0;
      first_addr_o <= '0;
      first_syn_o  <= '0;
    end else if (evt && !captured_q) begin
      captured_q   <= 1'b1;
      first_addr_o <= bus.addr_i;
      first_syn_o  <= bus.syndrome_i;
    end
  end
`else
  assign first_addr_o = '0;
  assign first_syn_o  = '0;
`endif

endmodule

// File: tb/tb_ecc_err_logger.sv
// Randomized self-checking bench for ecc_err_logger against a queue-based reference model.
// Honours ECC_LOG_FIRST_ERR_EN the same way as the design.
module tb_ecc_err_logger;
  localparam int unsigned SYN_W     = 5;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LOG_DEPTH = 4;
  localparam int unsigned SB_THRESH = 8;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr, ack;
  logic [CNT_W-1:0]  sb_cnt, db_cnt;
  logic              ovf, irq;
  logic [ADDR_W-1:0] first_addr;
  logic [SYN_W-1:0]  first_syn;

  ecc_err_logger_if #(.ADDR_W(ADDR_W), .SYN_W(SYN_W)) bus ();

  ecc_err_logger #(
    .SYN_W(SYN_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .LOG_DEPTH(LOG_DEPTH), .SB_THRESH(SB_THRESH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .clr_i(clr), .irq_ack_i(ack),
    .sb_cnt_o(sb_cnt), .db_cnt_o(db_cnt), .ovf_o(ovf), .irq_o(irq),
    .first_addr_o(first_addr), .first_syn_o(first_syn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SYN_W-1:0]  syn;
    logic              db;
    logic              fix;
  } rec_t;

  rec_t              m_q[$];
  int                m_sb, m_db;
  bit                m_ovf, m_irq, m_cap;
  logic [ADDR_W-1:0] m_faddr;
  logic [SYN_W-1:0]  m_fsyn;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sb = 0; m_db = 0; m_ovf = 0; m_irq = 0; m_cap = 0;
    m_faddr = '0; m_fsyn = '0;
  endtask

  task automatic compare_outputs();
    rec_t head;
    check_eq("sb_cnt", 64'(sb_cnt), 64'(m_sb));
    check_eq("db_cnt", 64'(db_cnt), 64'(m_db));
    check_eq("ovf", 64'(ovf), 64'(m_ovf));
    check_eq("irq", 64'(irq), 64'(m_irq));
    check_eq("rec_valid", 64'(bus.rec_valid_o), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      head = m_q[0];
      check_eq("rec_addr", 64'(bus.rec_addr_o), 64'(head.addr));
      check_eq("rec_syn", 64'(bus.rec_syn_o), 64'(head.syn));
      check_eq("rec_db", 64'(bus.rec_db_o), 64'(head.db));
      check_eq("rec_fix", 64'(bus.rec_fix_o), 64'(head.fix));
    end
    check_eq("first_addr", 64'(first_addr), 64'(m_faddr));
    check_eq("first_syn", 64'(first_syn), 64'(m_fsyn));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit v, input bit sb, input bit db, input bit fix,
                      input logic [ADDR_W-1:0] addr, input logic [SYN_W-1:0] syn,
                      input bit rdy, input bit c, input bit a);
    bit ev, pop, full, trig;
    rec_t r;
    bus.valid_i = v; bus.sb_err_i = sb; bus.db_err_i = db; bus.sb_fix_i = fix;
    bus.addr_i = addr; bus.syndrome_i = syn; bus.rec_ready_i = rdy;
    clr = c; ack = a;
    if (c) begin
      model_reset();
    end else begin
      ev   = v && (sb || db);
      pop  = (m_q.size() != 0) && rdy;
      full = (m_q.size() == LOG_DEPTH);
      trig = 0;
      if (pop) void'(m_q.pop_front());
      if (ev) begin
        if (db) begin
          if (m_db < CNT_MAX) m_db++;
          trig = 1;
        end else if (m_sb < CNT_MAX) begin
          m_sb++;
          if (m_sb == SB_THRESH) trig = 1;
        end
        r.addr = addr; r.syn = syn; r.db = db; r.fix = fix;
        if (!full || pop) m_q.push_back(r);
        else m_ovf = 1;
`ifdef ECC_LOG_FIRST_ERR_EN
        if (!m_cap) begin
          m_cap = 1; m_faddr = addr; m_fsyn = syn;
        end
`endif
      end
      if (trig) m_irq = 1;
      else if (a) m_irq = 0;
    end
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, rdy, 0, 0);
  endtask

  task automatic sb_evt(input logic [ADDR_W-1:0] addr, input bit rdy);
    step(1, 1, 0, 1, addr, 5'b00111, rdy, 0, 0);
  endtask

  task automatic rand_step(input int rdy_pct);
    bit v, sb, db;
    v  = ($urandom_range(0, 3) != 0);
    sb = $urandom_range(0, 1) != 0;
    db = ($urandom_range(0, 4) == 0);
    step(v, sb, db, $urandom_range(0, 1) != 0, ADDR_W'($urandom), SYN_W'($urandom),
         $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 79) == 0,
         $urandom_range(0, 5) == 0);
  endtask

  initial begin
    bus.valid_i = 0; bus.sb_err_i = 0; bus.db_err_i = 0; bus.sb_fix_i = 0;
    bus.addr_i = '0; bus.syndrome_i = '0; bus.rec_ready_i = 0;
    clr = 0; ack = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_rec_valid", 64'(bus.rec_valid_o), 64'(0));
    check_eq("rst_irq", 64'(irq), 64'(0));
    compare_outputs();
    rst_n = 1'b1;

    // single sb event shows up at the FIFO head one cycle later
    step(1, 1, 0, 0, 10'h12, 5'b00111, 0, 0, 0);
    check_eq("t1_addr", 64'(bus.rec_addr_o), 64'h12);
    check_eq("t1_syn", 64'(bus.rec_syn_o), 64'h07);
    idle(2, 1);

    // db event raises irq, ack clears it
    step(1, 0, 1, 0, 10'h21, 5'b00110, 1, 0, 0);
    check_eq("t2_irq", 64'(irq), 64'(1));
    step(0, 0, 0, 0, '0, '0, 1, 0, 1);
    check_eq("t2_irq_ack", 64'(irq), 64'(0));
    // ack coincident with a new db trigger keeps irq pending
    step(1, 0, 1, 0, 10'h22, 5'b00101, 1, 0, 0);
    step(1, 0, 1, 0, 10'h23, 5'b00101, 1, 0, 1);
    step(0, 0, 0, 0, '0, '0, 1, 0, 1);

    // threshold crossing fires once
    step(0, 0, 0, 0, '0, '0, 1, 1, 0);
    for (int i = 0; i < 8; i++) sb_evt(ADDR_W'(i), 1);
    check_eq("t3_irq_at_thresh", 64'(irq), 64'(1));
    step(0, 0, 0, 0, '0, '0, 1, 0, 1);
    sb_evt(10'h99, 1);
    check_eq("t3_no_refire", 64'(irq), 64'(0));

    // overflow with stalled consumer, then full with simultaneous push and pop
    step(0, 0, 0, 0, '0, '0, 1, 1, 0);
    for (int i = 0; i < 5; i++) sb_evt(ADDR_W'(10'h100 + i), 0);
    check_eq("t4_ovf", 64'(ovf), 64'(1));
    check_eq("t4_head", 64'(bus.rec_addr_o), 64'h100);
    sb_evt(10'h1ff, 1);
    idle(5, 1);

    // clear with coincident event discards the event
    sb_evt(10'h55, 0);
    step(1, 0, 1, 0, 10'h56, 5'b00011, 0, 1, 0);
    check_eq("t5_valid", 64'(bus.rec_valid_o), 64'(0));
    check_eq("t5_db", 64'(db_cnt), 64'(0));

    // first-event capture and rearm
    sb_evt(10'h20, 1);
    sb_evt(10'h30, 1);
    step(0, 0, 0, 0, '0, '0, 1, 1, 0);
    sb_evt(10'h40, 1);

    // saturation: counter sticks at all-ones, no refire
    for (int i = 0; i < 20; i++) sb_evt(ADDR_W'(i), 1);
    check_eq("sat_sb", 64'(sb_cnt), 64'(CNT_MAX));

    for (int i = 0; i < 300; i++) rand_step(70);
    for (int i = 0; i < 300; i++) rand_step(20);

    // asynchronous reset mid-burst clears everything before the next edge
    for (int i = 0; i < 6; i++) rand_step(10);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_valid", 64'(bus.rec_valid_o), 64'(0));
    check_eq("arst_sb", 64'(sb_cnt), 64'(0));
    check_eq("arst_db", 64'(db_cnt), 64'(0));
    check_eq("arst_irq", 64'(irq), 64'(0));
    check_eq("arst_ovf", 64'(ovf), 64'(0));
    check_eq("arst_first", 64'(first_addr), 64'(0));
    bus.valid_i = 0; clr = 0; ack = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) rand_step(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
